// File: rtl/pp_col_reduce.sv
// Streaming multi-lane column aggregator: reduces a masked, valid/ready column of signed
// elements to one SUM/MIN/MAX/COUNT/NNZ scalar via per-lane accumulators and a serial fold.
module pp_col_reduce #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = WIDTH + 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     start,
    input  logic [2:0]               cmd,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]         in_mask,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_result,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_ovf,
    output logic                     out_err,
    output logic                     busy
);

    typedef enum logic [1:0] {StIdle, StRun, StFold, StDone} state_e;

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [2:0] CmdSum   = 3'd0;
    localparam logic [2:0] CmdMin   = 3'd1;
    localparam logic [2:0] CmdMax   = 3'd2;
    localparam logic [2:0] CmdCount = 3'd3;
    localparam logic [2:0] CmdNnz   = 3'd4;

    // Returns {saturated, value}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    // Shared by lane update and fold; b is already the operand (element, 1, x!=0 or lane acc).
    function automatic logic [ACC_W:0] combine(input logic [2:0] op,
                                               input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b,
                                               input logic first);
        logic [ACC_W:0] s;
        combine = {1'b0, a};
        s = sat_add(a, b);
        case (op)
            CmdSum:           combine = s;
            CmdCount, CmdNnz: combine = {1'b0, s[ACC_W-1:0]};
            CmdMin:           combine = {1'b0, (first || (b < a)) ? b : a};
            CmdMax:           combine = {1'b0, (first || (b > a)) ? b : a};
            default:          ;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              cmd_q, cmd_d;
    logic                    err_q, err_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];
    logic [LANES-1:0]        seen_q, seen_d;
    logic signed [ACC_W-1:0] fold_q, fold_d;
    logic                    fold_seen_q, fold_seen_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic                    accept, start_ok, last_fold;
    logic signed [WIDTH-1:0] x;
    logic signed [ACC_W-1:0] opnd;
    logic [ACC_W:0]          r;
    logic [CNT_W:0]          pop, cnt_ext;

    assign in_ready  = enable && (state_q == StRun);
    assign accept    = in_ready && in_valid;
    assign start_ok  = enable && start && (state_q == StIdle);
    assign last_fold = (idx_q == IDX_W'(LANES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            seen_q      <= '0;
            fold_q      <= '0;
            fold_seen_q <= 1'b0;
            idx_q       <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            fold_q      <= fold_d;
            fold_seen_q <= fold_seen_d;
            idx_q       <= idx_d;
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (in_valid && in_last) state_d = StFold;
                StFold:  if (last_fold) state_d = StDone;
                StDone:  if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cmd_d       = cmd_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        fold_d      = fold_q;
        fold_seen_d = fold_seen_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        x           = '0;
        opnd        = '0;
        r           = '0;
        pop         = '0;
        cnt_ext     = '0;
        if (start_ok) begin
            cmd_d       = cmd;
            err_d       = (cmd > CmdNnz);
            ovf_d       = 1'b0;
            cnt_d       = '0;
            seen_d      = '0;
            fold_d      = '0;
            fold_seen_d = 1'b0;
            idx_d       = '0;
            for (int i = 0; i < LANES; i++) acc_d[i] = '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_mask[i]) begin
                    x = in_data[i*WIDTH +: WIDTH];
                    case (cmd_q)
                        CmdCount: opnd = {{(ACC_W-1){1'b0}}, 1'b1};
                        CmdNnz:   opnd = {{(ACC_W-1){1'b0}}, (x != '0)};
                        default:  opnd = ACC_W'(x);
                    endcase
                    r        = combine(cmd_q, acc_q[i], opnd, !seen_q[i]);
                    acc_d[i] = r[ACC_W-1:0];
                    ovf_d    = ovf_d | r[ACC_W];
                end
                pop = pop + {{CNT_W{1'b0}}, in_mask[i]};
            end
            seen_d  = seen_q | in_mask;
            cnt_ext = {1'b0, cnt_q} + pop;
            cnt_d   = cnt_ext[CNT_W-1:0];
            ovf_d   = ovf_d | cnt_ext[CNT_W];
        end else if (enable && (state_q == StFold)) begin
            // Lanes that never saw an element must not seed MIN/MAX with their zero.
            if (seen_q[idx_q]) begin
                r           = combine(cmd_q, fold_q, acc_q[idx_q], !fold_seen_q);
                fold_d      = r[ACC_W-1:0];
                fold_seen_d = 1'b1;
                ovf_d       = ovf_q | r[ACC_W];
            end
            idx_d = last_fold ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        out_valid  = (state_q == StDone);
        busy       = (state_q != StIdle);
        out_result = (out_valid && !err_q && fold_seen_q) ? fold_q : '0;
        out_count  = out_valid ? cnt_q : '0;
        out_ovf    = out_valid && ovf_q;
        out_err    = out_valid && err_q;
    end

endmodule

// File: tb/tb_pp_col_reduce.sv
// Scoreboard bench for pp_col_reduce: directed columns push expected results, a negedge
// monitor pops and compares on every output handshake.
module tb_pp_col_reduce;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned ACC_W = 33;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [ACC_W-1:0] result;
        logic [CNT_W-1:0] count;
        logic             ovf;
        logic             err;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   enable;
    logic                   start;
    logic [2:0]             cmd;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       in_mask;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_result;
    logic [CNT_W-1:0]       out_count;
    logic                   out_ovf;
    logic                   out_err;
    logic                   busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    pp_col_reduce #(
        .WIDTH(WIDTH),
        .LANES(LANES),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .cmd       (cmd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ACC_W-1:0] r, input logic [CNT_W-1:0] c,
                        input logic o, input logic e);
        exp_t x;
        x.result = r;
        x.count  = c;
        x.ovf    = o;
        x.err    = e;
        sb_q.push_back(x);
    endtask

    task automatic begin_col(input logic [2:0] c);
        cmd   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3,
                        input logic [LANES-1:0] m, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = {d3, d2, d1, d0};
        in_mask  = m;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("beat_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {out_valid, in_ready, busy, out_ovf, out_err, out_result, out_count}, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("result", out_result, e.result);
                chk("count", out_count, e.count);
                chk("ovf", out_ovf, e.ovf);
                chk("err", out_err, e.err);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        start     = 1'b0;
        cmd       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk_all_zero("reset_state");
        reset_n = 1'b1;
        tick();

        // SUM with exact latency check
        begin_col(3'd0);
        push(36, 8, 0, 0);
        beat(1, 2, 3, 4, 4'b1111, 0);
        beat(5, 6, 7, 8, 4'b1111, 1);
        tick(); tick(); tick();
        chk("latency_early", out_valid, 0);
        tick();
        chk("latency_on_time", out_valid, 1);
        wait_idle();

        // MIN with partial masks
        begin_col(3'd1);
        push(-8, 5, 0, 0);
        beat(-3, 9, 7, 0, 4'b1011, 0);
        beat(12, -8, 4, 4, 4'b0110, 1);
        wait_idle();

        // SUM saturation at 33-bit accumulator
        begin_col(3'd0);
        push(33'h0_FFFF_FFFF, 8, 1, 0);
        beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b1111, 0);
        beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b1111, 1);
        wait_idle();

        // Empty column under MAX
        begin_col(3'd2);
        push(0, 0, 0, 0);
        beat(7, 7, 7, 7, 4'b0000, 1);
        wait_idle();

        // MAX of all-negative elements
        begin_col(3'd2);
        push(-2, 4, 0, 0);
        beat(-5, -2, -9, -7, 4'b1111, 1);
        wait_idle();

        // COUNT
        begin_col(3'd3);
        push(5, 5, 0, 0);
        beat(0, 0, 0, 0, 4'b0101, 0);
        beat(3, -1, 0, 9, 4'b1110, 1);
        wait_idle();

        // Illegal cmd still consumes the column
        begin_col(3'd6);
        push(0, 4, 0, 1);
        beat(1, 2, 3, 4, 4'b1111, 1);
        wait_idle();

        // Hold in DONE with start pulses and enable toggling
        out_ready = 1'b0;
        begin_col(3'd0);
        push(100, 4, 0, 0);
        beat(10, 20, 30, 40, 4'b1111, 1);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 10; i++) begin
            start  = (i % 3 == 0);
            cmd    = 3'd2;
            enable = (i % 2 == 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, 100);
            chk("hold_count", out_count, 4);
            tick();
        end
        start     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_hs", busy, 0);
        chk("cleared_after_hs", {out_valid, out_result, out_count}, 0);
        tick();
        chk("no_new_column", busy, 0);

        // Abort mid-RUN, then a clean NNZ column
        begin_col(3'd0);
        beat(100, 100, 100, 100, 4'b1111, 0);
        beat(100, 100, 100, 100, 4'b1111, 0);
        beat(100, 100, 100, 100, 4'b1111, 0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort_zero");
        tick();
        reset_n = 1'b1;
        tick();
        begin_col(3'd4);
        push(2, 4, 0, 0);
        beat(0, 5, 0, -1, 4'b1111, 1);
        wait_idle();

        tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
